// File: rtl/fifo_buffer.sv
// fifo_buffer: parametrised first-word-fall-through FIFO with valid/ready
// handshakes on both sides. It decouples producer and consumer stalls in the
// datapath. in_ready depends only on the stored count, so there is no
// combinational path from out_ready to in_ready.
module fifo_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        push, pop;

  // Handshake status and output data.
  // out_data is masked to zero when empty, so stale or uninitialised
  // storage never reaches the consumer.
  always_comb begin
    in_ready  = (count_q != CW'(DEPTH));
    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    count     = count_q;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Next-state for the pointers, the count and the storage.
  // A clear (reset or flush) discards any push or pop in the same cycle.
  // Pointers are log2(DEPTH) bits wide, so they wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers. Reset has priority over flush and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array. It is deliberately not cleared by reset, but a write is
  // suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed and randomised checks of fifo_buffer against a
// queue-based reference model of the FIFO contents.
module tb_fifo_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  int checks = 0;
  int passed = 0;

  logic [WIDTH-1:0] model_q[$];

  fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compare every output against the model's view of the current contents.
  task automatic check_model(input string tag);
    int n;
    n = model_q.size();
    check({tag, ".count"},     32'(count),     32'(n));
    check({tag, ".in_ready"},  32'(in_ready),  32'(n < DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(n > 0));
    check({tag, ".out_data"},  32'(out_data),  (n > 0) ? 32'(model_q[0]) : 32'd0);
  endtask

  // Drive one cycle: check the pre-edge outputs, then advance the model.
  task automatic cycle(input string tag, input logic r, input logic f, input logic iv,
                       input logic [WIDTH-1:0] d, input logic ordy);
    logic do_push, do_pop;
    logic [WIDTH-1:0] tmp;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    check_model(tag);
    @(posedge clk);
    if (r || f) begin
      model_q.delete();
    end else begin
      do_push = iv && (model_q.size() < DEPTH);
      do_pop  = ordy && (model_q.size() > 0);
      if (do_pop) tmp = model_q.pop_front();
      if (do_push) model_q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    // Hold reset for two cycles from an unknown state.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.count", 32'(count), 32'd0);
    check("reset.out_data", 32'(out_data), 32'd0);
    cycle("idle", 0, 0, 0, 8'h00, 0);

    // Fill with the consumer stalled, then attempt a fifth push.
    cycle("fill0", 0, 0, 1, 8'h11, 0);
    cycle("fill1", 0, 0, 1, 8'h22, 0);
    cycle("fill2", 0, 0, 1, 8'h33, 0);
    cycle("fill3", 0, 0, 1, 8'h44, 0);
    check("full.count", 32'(count), 32'd4);
    check("full.in_ready", 32'(in_ready), 32'd0);
    cycle("refuse", 0, 0, 1, 8'h55, 0);
    check("refuse.head", 32'(out_data), 32'h11);

    // Drain in order.
    cycle("drain0", 0, 0, 0, 8'h00, 1);
    cycle("drain1", 0, 0, 0, 8'h00, 1);
    cycle("drain2", 0, 0, 0, 8'h00, 1);
    cycle("drain3", 0, 0, 0, 8'h00, 1);
    check("drained.out_valid", 32'(out_valid), 32'd0);
    check("drained.count", 32'(count), 32'd0);

    // Simultaneous push and pop at count 2, wrapping the pointers.
    cycle("pre0", 0, 0, 1, 8'hB0, 0);
    cycle("pre1", 0, 0, 1, 8'hB1, 0);
    for (int i = 0; i < 6; i++) cycle("pushpop", 0, 0, 1, 8'(8'hA0 + i), 1);
    check("pushpop.count", 32'(count), 32'd2);
    check("pushpop.head", 32'(out_data), 32'hA4);

    // Full with a same-cycle pop: the push is refused.
    cycle("top0", 0, 0, 1, 8'hC0, 0);
    cycle("top1", 0, 0, 1, 8'hC1, 0);
    cycle("fullpop", 0, 0, 1, 8'h99, 1);
    check("fullpop.count", 32'(count), 32'd3);
    check("fullpop.in_ready", 32'(in_ready), 32'd1);

    // Flush at count 3 with a concurrent push, then restart.
    cycle("flush", 0, 1, 1, 8'h77, 1);
    check("flush.count", 32'(count), 32'd0);
    check("flush.out_data", 32'(out_data), 32'd0);
    cycle("postflush", 0, 0, 1, 8'h5A, 0);
    check("postflush.out_data", 32'(out_data), 32'h5A);

    // The same sequence using reset instead of flush.
    cycle("rfill0", 0, 0, 1, 8'h61, 0);
    cycle("rfill1", 0, 0, 1, 8'h62, 0);
    cycle("rst", 1, 0, 1, 8'h78, 1);
    check("rst.count", 32'(count), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    cycle("postrst", 0, 0, 1, 8'h5A, 0);
    check("postrst.out_data", 32'(out_data), 32'h5A);
    cycle("empty_out", 0, 0, 0, 8'h00, 1);

    // Pops at empty are ignored.
    for (int i = 0; i < 3; i++) cycle("emptypop", 0, 0, 0, 8'h00, 1);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(63) == 0), ($urandom_range(31) == 0),
            1'($urandom), 8'($urandom), 1'($urandom));
    end
    #1;
    check_model("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
